// File: rtl/demux_2x32_buf.sv
// One-to-two demultiplexer. Each output port has its own 2-entry FIFO and
// a counter of delivered words.

module demux_2x32_buf_lane #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state, state_nxt;
    logic [WIDTH-1:0] slot0, slot1, slot0_nxt, slot1_nxt;
    logic             pop;

    // slot0 is always the head; a pop from FULL shifts slot1 forward
    assign pop   = (state != EMPTY) && ready;
    assign data  = slot0;
    assign valid = (state != EMPTY);
    assign full  = (state == FULL);

    always_comb begin
        state_nxt = state;
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        case (state)
            EMPTY: begin
                if (push) begin
                    slot0_nxt = wdata;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    slot0_nxt = wdata;
                end else if (push) begin
                    slot1_nxt = wdata;
                    state_nxt = FULL;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    slot0_nxt = slot1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            slot0 <= slot0_nxt;
            slot1 <= slot1_nxt;
            if (pop) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

module demux_2x32_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic full0, full1;
    logic push0, push1;

    // Readiness looks only at the selected FIFO's occupancy, never at the pops
    assign in_ready = in_sel ? !full1 : !full0;
    assign push0    = in_valid && in_ready && !in_sel;
    assign push1    = in_valid && in_ready && in_sel;

    demux_2x32_buf_lane #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_lane0 (
        .clk  (clk),
        .rst  (rst),
        .push (push0),
        .wdata(in_data),
        .ready(out0_ready),
        .data (out0_data),
        .valid(out0_valid),
        .full (full0),
        .cnt  (cnt0)
    );

    demux_2x32_buf_lane #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_lane1 (
        .clk  (clk),
        .rst  (rst),
        .push (push1),
        .wdata(in_data),
        .ready(out1_ready),
        .data (out1_data),
        .valid(out1_valid),
        .full (full1),
        .cnt  (cnt1)
    );

endmodule

// File: tb/tb_demux_2x32_buf.sv
// Directed bench for demux_2x32_buf with hand-computed expectations.

module tb_demux_2x32_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data, out1_data;
    logic        out0_valid, out1_valid;
    logic        out0_ready, out1_ready;
    logic [15:0] cnt0, cnt1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    demux_2x32_buf #(
        .WIDTH(32),
        .CNT_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data (out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_v0", 32'(out0_valid), 32'd0);
        check("rst_v1", 32'(out1_valid), 32'd0);
        check("rst_c0", 32'(cnt0), 32'd0);
        check("rst_c1", 32'(cnt1), 32'd0);
        check("rst_d0", out0_data, 32'd0);
        check("rst_d1", out1_data, 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);

        // Single word to port 0
        drive(1'b1, 1'b0, 32'h0000_00AA);
        step();
        drive(1'b0, 1'b1, 32'hDEAD_BEEF);
        check("t1_v0", 32'(out0_valid), 32'd1);
        check("t1_d0", out0_data, 32'h0000_00AA);
        check("t1_v1", 32'(out1_valid), 32'd0);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        check("t1_c0", 32'(cnt0), 32'd1);
        check("t1_v0_after", 32'(out0_valid), 32'd0);

        // Fill port 0 while blocked, route around it to port 1
        drive(1'b1, 1'b0, 32'h11);
        step();
        drive(1'b1, 1'b0, 32'h22);
        step();
        drive(1'b1, 1'b0, 32'h99);
        check("t2_full_rdy", 32'(in_ready), 32'd0);
        step();
        check("t2_hold_d0", out0_data, 32'h11);
        drive(1'b1, 1'b1, 32'h33);
        check("t2_sel1_rdy", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check("t2_v1", 32'(out1_valid), 32'd1);
        check("t2_d1", out1_data, 32'h33);
        check("t2_d0_first", out0_data, 32'h11);
        out0_ready = 1'b1;
        step();
        check("t2_d0_second", out0_data, 32'h22);
        check("t2_v0_second", 32'(out0_valid), 32'd1);
        step();
        out0_ready = 1'b0;
        check("t2_v0_empty", 32'(out0_valid), 32'd0);
        check("t2_c0", 32'(cnt0), 32'd3);
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        check("t2_c1", 32'(cnt1), 32'd1);
        check("t2_v1_empty", 32'(out1_valid), 32'd0);

        // Simultaneous push and pop at ONE
        drive(1'b1, 1'b0, 32'h11);
        step();
        out0_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h22);
        step();
        out0_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("t3_d0", out0_data, 32'h22);
        check("t3_v0", 32'(out0_valid), 32'd1);
        check("t3_rdy_one", 32'(in_ready), 32'd1);
        check("t3_c0", 32'(cnt0), 32'd4);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        check("t3_v0_empty", 32'(out0_valid), 32'd0);
        check("t3_c0_b", 32'(cnt0), 32'd5);

        // FULL with pop: push refused this cycle, slot free next cycle
        drive(1'b1, 1'b0, 32'h44);
        step();
        drive(1'b1, 1'b0, 32'h55);
        step();
        out0_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h66);
        check("t4_rdy_full", 32'(in_ready), 32'd0);
        step();
        check("t4_rdy_next", 32'(in_ready), 32'd1);
        check("t4_d0", out0_data, 32'h55);
        drive(1'b0, 1'b0, 32'h0);
        step();
        out0_ready = 1'b0;
        check("t4_v0_empty", 32'(out0_valid), 32'd0);
        check("t4_c0", 32'(cnt0), 32'd7);

        // Stream port 1 until cnt1 reaches 0xFFFF (it starts at 1)
        out1_ready = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            drive(1'b1, 1'b1, 32'(i) ^ 32'h5A5A_0000);
            step();
            if (i == 0 || i == 1 || i == 40000) begin
                check("t5_stream_d1", out1_data, 32'(i) ^ 32'h5A5A_0000);
            end
        end
        drive(1'b0, 1'b1, 32'h0);
        step();
        check("t5_c1_max", 32'(cnt1), 32'h0000_FFFF);
        check("t5_v1_empty", 32'(out1_valid), 32'd0);
        drive(1'b1, 1'b1, 32'h77);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check("t5_c1_hold", 32'(cnt1), 32'h0000_FFFF);
        check("t5_d1", out1_data, 32'h77);
        step();
        out1_ready = 1'b0;
        check("t5_c1_wrap", 32'(cnt1), 32'd0);

        // Both FIFOs FULL, then reset with a competing push and pops
        drive(1'b1, 1'b0, 32'hA1);
        step();
        drive(1'b1, 1'b0, 32'hA2);
        step();
        drive(1'b1, 1'b1, 32'hB1);
        step();
        drive(1'b1, 1'b1, 32'hB2);
        step();
        check("t6_rdy1_full", 32'(in_ready), 32'd0);
        drive(1'b1, 1'b0, 32'hEE);
        check("t6_rdy0_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("t6_v0", 32'(out0_valid), 32'd0);
        check("t6_v1", 32'(out1_valid), 32'd0);
        check("t6_c0", 32'(cnt0), 32'd0);
        check("t6_c1", 32'(cnt1), 32'd0);
        check("t6_d0", out0_data, 32'd0);
        check("t6_d1", out1_data, 32'd0);
        check("t6_rdy", 32'(in_ready), 32'd1);
        step();
        check("t6_v0_stay", 32'(out0_valid), 32'd0);
        check("t6_v1_stay", 32'(out1_valid), 32'd0);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b1, 32'hC3);
        step();
        drive(1'b0, 1'b0, 32'h0);
        check("t6_new_d1", out1_data, 32'hC3);
        check("t6_new_v0", 32'(out0_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_2x32_buf.md
DEMUX_2X32_BUF -- requirements
Module: demux_2x32_buf

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data path width in bits.
REQ-002 SHALL provide parameter CNT_W, default 16, width of each per-port transfer counter.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port in_data, input, WIDTH, the input word.
REQ-006 SHALL have port in_sel, input, 1, the destination port: 0 routes to out0, 1 routes to out1.
REQ-007 SHALL have port in_valid, input, 1, the input word and in_sel are valid.
REQ-008 SHALL have port in_ready, output, 1, the block can accept the presented word.
REQ-009 SHALL have ports out0_data and out1_data, output, WIDTH, the head word of each port buffer.
REQ-010 SHALL have ports out0_valid and out1_valid, output, 1, the port buffer is non-empty.
REQ-011 SHALL have ports out0_ready and out1_ready, input, 1, the consumer accepts the head word.
REQ-012 SHALL have ports cnt0 and cnt1, output, CNT_W, the number of words delivered on each output port.

Function
REQ-013 SHALL define an input transfer as in_valid=1 and in_ready=1 on a rising edge.
REQ-014 SHALL define an output transfer on port k as outk_valid=1 and outk_ready=1 on a rising edge.
REQ-015 SHALL give each output port an independent 2-entry FIFO, with an occupancy state of EMPTY (0), ONE (1) or FULL (2).
REQ-016 SHALL drive in_ready combinationally as NOT FULL of the FIFO selected by in_sel.
REQ-017 SHALL NOT let in_ready depend on in_valid or on either outk_ready.
REQ-018 SHALL write an accepted word only into the FIFO selected by in_sel; the other FIFO is unaffected.
REQ-019 SHALL assert outk_valid on the cycle after the edge that writes into an EMPTY FIFO, for a latency of 1 cycle.
REQ-020 SHALL NOT provide a combinational in-to-out path.
REQ-021 SHALL drive outk_data from the head entry, and SHALL hold it stable while outk_valid=1 and outk_ready=0.
REQ-022 SHALL deliver words on each port in acceptance order, with no loss and no duplication.
REQ-023 SHALL apply these occupancy transitions: push only gives +1; pop only gives -1; push and pop in the same cycle leave occupancy unchanged and the order intact.
REQ-024 SHALL, when the FIFO is FULL, refuse a push (in_ready=0) even if a pop occurs in the same cycle; the freed slot becomes available on the next cycle.
REQ-025 SHALL ignore outk_ready when outk_valid=0; a pop from EMPTY has no effect.
REQ-026 SHALL allow both ports to pop in the same cycle as a push to either port.
REQ-027 SHALL ignore in_sel and in_data when in_valid=0.
REQ-028 SHALL increment cntk by 1 on each output transfer on port k.
REQ-029 SHALL wrap cntk modulo 2^CNT_W, so all-ones followed by a transfer gives 0.
REQ-030 SHALL NOT raise X or undefined state from out-of-range values, since all widths are exact.

Reset
REQ-031 SHALL, on rst=1 at a rising edge, set both FIFOs to EMPTY, set outk_valid=0, set cnt0=cnt1=0 and set outk_data to 0.
REQ-032 SHALL, when rst is asserted mid-operation, discard buffered words, accept no transfer on that edge, and have in_ready=1 on the following cycle.
REQ-033 SHALL let rst take precedence over any simultaneous push or pop.

Verification
REQ-034 Reset then in_sel=0, in_data=0x0000_00AA, one valid cycle -> next cycle out0_valid=1, out0_data=0x0000_00AA, out1_valid=0; after the pop with out0_ready=1, cnt0=1.
REQ-035 out0_ready=0, push 0x11, 0x22 to port 0 -> FIFO0 FULL and in_ready=0 while in_sel=0; with in_sel=1, in_ready=1 and 0x33 reaches out1; releasing out0_ready yields 0x11 then 0x22.
REQ-036 FIFO0 at ONE holding 0x11, push 0x22 with out0_ready=1 in the same cycle -> 0x11 delivered, 0x22 at head next cycle, occupancy stays ONE.
REQ-037 FIFO0 FULL with out0_ready=1 and in_valid=1, in_sel=0 -> push refused that cycle; in_ready=1 next cycle.
REQ-038 Preload cnt1 to 0xFFFF by 65535 transfers, then one more out1 transfer -> cnt1=0x0000.
REQ-039 Both FIFOs FULL, assert rst for one cycle -> out0_valid=out1_valid=0, cnt0=cnt1=0 and in_ready=1 next cycle; no old word ever appears at an output.
